// File: rtl/netlist_eval_pkg.sv
// Shared types for the levelized gate-netlist evaluation sequencer.
package netlist_eval_pkg;

  localparam int NET_W = 7;

  typedef enum logic [1:0] {
    GATE_AND  = 2'b00,
    GATE_OR   = 2'b01,
    GATE_XOR  = 2'b10,
    GATE_XNOR = 2'b11
  } gate_op_e;

  typedef struct packed {
    gate_op_e           op;
    logic [NET_W-1:0]   a;
    logic [NET_W-1:0]   b;
    logic [NET_W-1:0]   y;
  } gate_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/gate_eval_unit.sv
// Single shared combinational gate datapath: y = op(a, b).
module gate_eval_unit
  import netlist_eval_pkg::*;
(
  input  gate_op_e op,
  input  logic     a,
  input  logic     b,
  output logic     y
);

  always_comb begin
    y = 1'b0;
    case (op)
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_XOR:  y = a ^ b;
      GATE_XNOR: y = ~(a ^ b);
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/netlist_eval_sched.sv
// Evaluates a stored levelized netlist one gate per cycle and reports one net.
// Optional read-before-write hazard detection: NETLIST_EVAL_HAZARD_CHECK_EN.
module netlist_eval_sched
  import netlist_eval_pkg::*;
#(
  parameter  int NUM_PI    = 37,
  parameter  int NUM_NETS  = 96,
  parameter  int NUM_GATES = 64,
  localparam int NW        = $clog2(NUM_NETS),
  localparam int GW        = $clog2(NUM_GATES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [GW-1:0]     cfg_addr,
  input  logic [1:0]        cfg_op,
  input  logic [NW-1:0]     cfg_a,
  input  logic [NW-1:0]     cfg_b,
  input  logic [NW-1:0]     cfg_y,
  input  logic [NUM_PI-1:0] pi_val,
  input  logic [GW-1:0]     gate_count,
  input  logic              start,
  input  logic [NW-1:0]     po_idx,
  output logic              busy,
  output logic              done,
  output logic              po_val,
  output logic              err
);

  localparam int            TW       = $clog2(NUM_GATES);
  localparam logic [NW:0]   NET_LIM  = (NW+1)'(NUM_NETS);
  localparam logic [NW:0]   PI_LIM   = (NW+1)'(NUM_PI);
  localparam logic [GW-1:0] GATE_LIM = GW'(NUM_GATES);

  sched_state_e        state, state_d;
  logic [GW-1:0]       ptr, count;
  logic [NW-1:0]       po_sel;
  logic [NUM_NETS-1:0] nets, nets_d;
  gate_entry_t         tbl [NUM_GATES];
  gate_entry_t         ent;
  logic                a_inr, b_inr, a_val, b_val, y_val;
  logic                wr_en, hazard, last, po_d;

  // Gate table is configuration storage only; it is deliberately not reset.
  always_ff @(posedge clk) begin
    if (cfg_we && state == S_IDLE && cfg_addr < GATE_LIM)
      tbl[cfg_addr[TW-1:0]] <= '{op: gate_op_e'(cfg_op), a: cfg_a, b: cfg_b, y: cfg_y};
  end

  always_comb begin
    ent   = (ptr < GATE_LIM) ? tbl[ptr[TW-1:0]] : '0;
    a_inr = {1'b0, ent.a} < NET_LIM;
    b_inr = {1'b0, ent.b} < NET_LIM;
    a_val = a_inr ? nets[ent.a] : 1'b0;
    b_val = b_inr ? nets[ent.b] : 1'b0;
  end

  gate_eval_unit u_gate (
    .op (ent.op),
    .a  (a_val),
    .b  (b_val),
    .y  (y_val)
  );

`ifdef NETLIST_EVAL_HAZARD_CHECK_EN
  logic [NUM_NETS-1:0] valid, valid_d;
  logic                err_q;

  always_comb begin
    hazard = (state == S_EVAL) &&
             ((a_inr && !valid[ent.a]) || (b_inr && !valid[ent.b]));
  end

  always_comb begin
    valid_d = valid;
    if (state == S_LOAD) begin
      valid_d = NUM_NETS'({NUM_PI{1'b1}});
    end else begin
      for (int unsigned i = 0; i < NUM_NETS; i++)
        if (wr_en && ent.y == NW'(i)) valid_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      err_q <= 1'b0;
    end else begin
      valid <= valid_d;
      if (state == S_IDLE && start) err_q <= 1'b0;
      else if (hazard)              err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign hazard = 1'b0;
  assign err    = 1'b0;
`endif

  assign wr_en = (state == S_EVAL) && !hazard &&
                 ({1'b0, ent.y} >= PI_LIM) && ({1'b0, ent.y} < NET_LIM);
  assign last  = (ptr == count - GW'(1));
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = (count == '0) ? S_DONE : S_EVAL;
      S_EVAL:  if (hazard || last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nets_d = nets;
    if (state == S_LOAD) begin
      nets_d = NUM_NETS'(pi_val);
    end else begin
      for (int unsigned i = 0; i < NUM_NETS; i++)
        if (wr_en && ent.y == NW'(i)) nets_d[i] = y_val;
    end
  end

  // po_val is captured from the next-state net file on entry to DONE so it is
  // valid in the same cycle as the done pulse, including the last gate's write.
  always_comb begin
    po_d = ({1'b0, po_sel} < NET_LIM) ? nets_d[po_sel] : 1'b0;
    if (hazard) po_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      count  <= '0;
      po_sel <= '0;
      nets   <= '0;
      po_val <= 1'b0;
    end else begin
      state <= state_d;
      nets  <= nets_d;
      if (state == S_IDLE && start) begin
        count  <= gate_count;
        po_sel <= po_idx;
      end
      if (state == S_LOAD)      ptr <= '0;
      else if (state == S_EVAL) ptr <= ptr + GW'(1);
      if (state_d == S_DONE)    po_val <= po_d;
    end
  end

endmodule
